// File: rtl/din_sync_debounce.sv
// Raw asynchronous inputs are passed through a 2-flop synchronizer and a per-bit
// stability qualifier. The outputs are clean levels plus 1-cycle rise/fall pulses.
module din_sync_debounce_lane #(
   parameter int STABLE_CNT = 4,
   parameter int CNT_W      = 8
) (
   input  logic clk,
   input  logic reset,
   input  logic din,
   output logic dout,
   output logic rise,
   output logic fall,
   output logic busy
);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CNT - 1);

   logic             s1, s2;
   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         s1   <= 1'b0;
         s2   <= 1'b0;
         cnt  <= '0;
         dout <= 1'b0;
         rise <= 1'b0;
         fall <= 1'b0;
         busy <= 1'b0;
      end else begin
         s1   <= din;
         s2   <= s1;
         rise <= 1'b0;
         fall <= 1'b0;
         if (s2 == dout) begin
            // Any return to the accepted level discards the partial count.
            cnt  <= '0;
            busy <= 1'b0;
         end else if (cnt == LAST) begin
            dout <= s2;
            rise <= s2;
            fall <= ~s2;
            cnt  <= '0;
            busy <= 1'b0;
         end else begin
            cnt  <= cnt + 1'b1;
            busy <= 1'b1;
         end
      end
   end
endmodule

module din_sync_debounce #(
   parameter int WIDTH      = 4,
   parameter int STABLE_CNT = 4,
   parameter int CNT_W      = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic [WIDTH-1:0] rise,
   output logic [WIDTH-1:0] fall,
   output logic [WIDTH-1:0] busy
);
   for (genvar i = 0; i < WIDTH; i++) begin : g_lane
      din_sync_debounce_lane #(
         .STABLE_CNT(STABLE_CNT),
         .CNT_W     (CNT_W)
      ) u_lane (
         .clk  (clk),
         .reset(reset),
         .din  (din[i]),
         .dout (dout[i]),
         .rise (rise[i]),
         .fall (fall[i]),
         .busy (busy[i])
      );
   end
endmodule
